// File: rtl/riscv_pkg.sv
// Shared state, opcode, ALUOp and ALUControl encodings for the multicycle RISC-V controller.
// Optional feature macro: ILLEGAL_OP_EN (adds the HALT state for unrecognised opcodes).
package riscv_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10
`ifdef ILLEGAL_OP_EN
    , S_HALT   = 4'd11
`endif
  } state_t;

  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } alu_op_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  // Per-state Moore control word; ImmSrc and ALUControl are decoded separately.
  typedef struct packed {
    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    alu_op_t    alu_op;
  } ctrl_t;

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU operation decode from ALUOp, funct3, op[5] and funct7[5].
// Used by multicycle_controller; no configuration macros.
module alu_decoder
  import riscv_pkg::*;
(
  input  alu_op_t    alu_op,
  input  logic [2:0] funct3,
  input  logic       op_b5,
  input  logic       funct7b5,
  output logic [2:0] alu_control
);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_ADD: alu_control = ALU_ADD;
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          // Only R-type (op[5]=1) with funct7[5]=1 subtracts; addi never does.
          3'b000:  alu_control = (op_b5 && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RISC-V control FSM with ImmSrc decode; ALU decode lives in alu_decoder.
// Optional feature macro: ILLEGAL_OP_EN (HALT state plus sticky Illegal output).
module multicycle_controller
  import riscv_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [2:0] ALUControl
`ifdef ILLEGAL_OP_EN
  ,
  output logic       Illegal
`endif
);

  state_t state_q, state_d;
  ctrl_t  ctrl;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTER;
          OP_ITYPE:     state_d = S_EXECUTEI;
          OP_BEQ:       state_d = S_BEQ;
          OP_JAL:       state_d = S_JAL;
`ifdef ILLEGAL_OP_EN
          default:      state_d = S_HALT;
`else
          default:      state_d = S_FETCH;
`endif
        endcase
      end
      S_MEMADR:   state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  state_d = S_MEMWB;
      S_EXECUTER, S_EXECUTEI, S_JAL: state_d = S_ALUWB;
      S_MEMWB, S_MEMWRITE, S_ALUWB, S_BEQ: state_d = S_FETCH;
`ifdef ILLEGAL_OP_EN
      S_HALT:     state_d = S_HALT;
`endif
      default:    state_d = S_FETCH;
    endcase
  end

  always_comb begin
    ctrl = '0;
    case (state_q)
      S_FETCH: begin
        ctrl.ir_write   = 1'b1;
        ctrl.pc_write   = 1'b1;
        ctrl.alu_src_b  = 2'b10;
        ctrl.result_src = 2'b10;
      end
      S_DECODE: begin
        ctrl.alu_src_a = 2'b01;
        ctrl.alu_src_b = 2'b01;
      end
      S_MEMADR: begin
        ctrl.alu_src_a = 2'b10;
        ctrl.alu_src_b = 2'b01;
      end
      S_MEMREAD: ctrl.adr_src = 1'b1;
      S_MEMWB: begin
        ctrl.result_src = 2'b01;
        ctrl.reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        ctrl.adr_src   = 1'b1;
        ctrl.mem_write = 1'b1;
      end
      S_EXECUTER: begin
        ctrl.alu_src_a = 2'b10;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_EXECUTEI: begin
        ctrl.alu_src_a = 2'b10;
        ctrl.alu_src_b = 2'b01;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: ctrl.reg_write = 1'b1;
      S_BEQ: begin
        // The only Mealy output: branch is taken in the same cycle the compare resolves.
        ctrl.alu_src_a = 2'b10;
        ctrl.alu_op    = ALUOP_SUB;
        ctrl.pc_write  = Zero;
      end
      S_JAL: begin
        ctrl.alu_src_a = 2'b01;
        ctrl.alu_src_b = 2'b10;
        ctrl.pc_write  = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

  always_comb begin
    ImmSrc = 2'b00;
    case (op)
      OP_LW, OP_ITYPE: ImmSrc = 2'b00;
      OP_SW:           ImmSrc = 2'b01;
      OP_BEQ:          ImmSrc = 2'b10;
      OP_JAL:          ImmSrc = 2'b11;
      default:         ImmSrc = 2'b00;
    endcase
`ifdef ILLEGAL_OP_EN
    if (state_q == S_HALT) ImmSrc = 2'b00;
`endif
  end

  alu_decoder u_alu_decoder (
    .alu_op      (ctrl.alu_op),
    .funct3      (funct3),
    .op_b5       (op[5]),
    .funct7b5    (funct7b5),
    .alu_control (ALUControl)
  );

  assign PCWrite   = ctrl.pc_write;
  assign AdrSrc    = ctrl.adr_src;
  assign MemWrite  = ctrl.mem_write;
  assign IRWrite   = ctrl.ir_write;
  assign RegWrite  = ctrl.reg_write;
  assign ResultSrc = ctrl.result_src;
  assign ALUSrcA   = ctrl.alu_src_a;
  assign ALUSrcB   = ctrl.alu_src_b;

`ifdef ILLEGAL_OP_EN
  logic illegal_q, illegal_d;

  // Sticky: raised on the edge that enters HALT, cleared only by reset.
  assign illegal_d = illegal_q | (state_d == S_HALT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) illegal_q <= 1'b0;
    else       illegal_q <= illegal_d;
  end

  assign Illegal = illegal_q;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: a per-cycle scoreboard of expected control words.
// Builds with or without ILLEGAL_OP_EN; the HALT checks are compiled only when it is defined.
module tb_multicycle_controller;

  localparam int ST_F = 0, ST_D = 1, ST_MA = 2, ST_MR = 3, ST_MWB = 4, ST_MW = 5;
  localparam int ST_ER = 6, ST_EI = 7, ST_AWB = 8, ST_BEQ = 9, ST_JAL = 10, ST_HALT = 11;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;
`ifdef ILLEGAL_OP_EN
  logic       Illegal;
`endif

  int total = 0;
  int bad   = 0;
  logic [15:0] sb_q[$];
  logic [15:0] dut_vec;

  multicycle_controller dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .Zero       (Zero),
    .PCWrite    (PCWrite),
    .AdrSrc     (AdrSrc),
    .MemWrite   (MemWrite),
    .IRWrite    (IRWrite),
    .RegWrite   (RegWrite),
    .ResultSrc  (ResultSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ImmSrc     (ImmSrc),
    .ALUControl (ALUControl)
`ifdef ILLEGAL_OP_EN
    ,
    .Illegal    (Illegal)
`endif
  );

  always #5 clk = ~clk;

  assign dut_vec = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
                    ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl};

  // Reference control word: {PCWrite,AdrSrc,MemWrite,IRWrite,RegWrite,ResultSrc,ALUSrcA,ALUSrcB,ImmSrc,ALUControl}
  function automatic logic [15:0] exp_vec(int st, logic [6:0] o, logic [2:0] f3, logic f7, logic z);
    logic       pcw, adr, mw, irw, rw;
    logic [1:0] rs, sa, sb, imm, aop;
    logic [2:0] ac;
    {pcw, adr, mw, irw, rw} = 5'b0;
    {rs, sa, sb, aop} = 8'b0;
    case (st)
      ST_F:   begin pcw = 1; irw = 1; sb = 2'b10; rs = 2'b10; end
      ST_D:   begin sa = 2'b01; sb = 2'b01; end
      ST_MA:  begin sa = 2'b10; sb = 2'b01; end
      ST_MR:  adr = 1;
      ST_MWB: begin rs = 2'b01; rw = 1; end
      ST_MW:  begin adr = 1; mw = 1; end
      ST_ER:  begin sa = 2'b10; aop = 2'b10; end
      ST_EI:  begin sa = 2'b10; sb = 2'b01; aop = 2'b10; end
      ST_AWB: rw = 1;
      ST_BEQ: begin sa = 2'b10; aop = 2'b01; pcw = z; end
      ST_JAL: begin sa = 2'b01; sb = 2'b10; pcw = 1; end
      default: ;
    endcase
    case (o)
      7'h23:   imm = 2'b01;
      7'h63:   imm = 2'b10;
      7'h6F:   imm = 2'b11;
      default: imm = 2'b00;
    endcase
    if (st == ST_HALT) imm = 2'b00;
    case (aop)
      2'b01:   ac = 3'b001;
      2'b10:
        case (f3)
          3'b000:  ac = (o[5] && f7) ? 3'b001 : 3'b000;
          3'b010:  ac = 3'b101;
          3'b110:  ac = 3'b011;
          3'b111:  ac = 3'b010;
          default: ac = 3'b000;
        endcase
      default: ac = 3'b000;
    endcase
    return {pcw, adr, mw, irw, rw, rs, sa, sb, imm, ac};
  endfunction

  // Called just after a rising edge with the DUT in FETCH; returns just after the edge that ends the instruction.
  task automatic run_instr(string name, logic [6:0] o, logic [2:0] f3, logic f7, logic z);
    int seq[$];
    logic [15:0] exp;
    int cyc;
    op = o; funct3 = f3; funct7b5 = f7; Zero = z;
    seq.push_back(ST_F);
    seq.push_back(ST_D);
    case (o)
      7'h03: begin seq.push_back(ST_MA); seq.push_back(ST_MR); seq.push_back(ST_MWB); end
      7'h23: begin seq.push_back(ST_MA); seq.push_back(ST_MW); end
      7'h33: begin seq.push_back(ST_ER); seq.push_back(ST_AWB); end
      7'h13: begin seq.push_back(ST_EI); seq.push_back(ST_AWB); end
      7'h63: seq.push_back(ST_BEQ);
      7'h6F: begin seq.push_back(ST_JAL); seq.push_back(ST_AWB); end
      default: begin
`ifdef ILLEGAL_OP_EN
        repeat (3) seq.push_back(ST_HALT);
`endif
      end
    endcase
    foreach (seq[i]) sb_q.push_back(exp_vec(seq[i], o, f3, f7, z));
    cyc = 1;
    while (sb_q.size() > 0) begin
      @(negedge clk);
      exp = sb_q.pop_front();
      total++;
      if (dut_vec !== exp) begin
        bad++;
        $display("FAIL %s cycle %0d: got %b expected %b", name, cyc, dut_vec, exp);
      end
      cyc++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    op = 7'h00; funct3 = 3'b000; funct7b5 = 1'b0; Zero = 1'b0;
    reset = 1'b1;
    #3;
    total++;
    if (dut_vec !== exp_vec(ST_F, op, funct3, funct7b5, Zero)) begin
      bad++;
      $display("FAIL reset_state: got %b expected %b", dut_vec, exp_vec(ST_F, op, funct3, funct7b5, Zero));
    end
`ifdef ILLEGAL_OP_EN
    total++;
    if (Illegal !== 1'b0) begin
      bad++;
      $display("FAIL reset_illegal: got %b expected 0", Illegal);
    end
`endif
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset_mid_memread();
    op = 7'h03; funct3 = 3'b010; funct7b5 = 1'b0; Zero = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (dut_vec !== exp_vec(ST_MR, op, funct3, funct7b5, Zero)) begin
      bad++;
      $display("FAIL pre_reset_memread: got %b expected %b", dut_vec, exp_vec(ST_MR, op, funct3, funct7b5, Zero));
    end
    #2;
    reset = 1'b1;
    #1;
    total++;
    if (dut_vec !== exp_vec(ST_F, op, funct3, funct7b5, Zero)) begin
      bad++;
      $display("FAIL async_reset_memread: got %b expected %b", dut_vec, exp_vec(ST_F, op, funct3, funct7b5, Zero));
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_memory();
    run_instr("lw", 7'h03, 3'b010, 1'b0, 1'b0);
    run_instr("sw", 7'h23, 3'b010, 1'b1, 1'b1);
  endtask

  task automatic test_alu_ops();
    run_instr("r_add",  7'h33, 3'b000, 1'b0, 1'b0);
    run_instr("r_sub",  7'h33, 3'b000, 1'b1, 1'b0);
    run_instr("r_slt",  7'h33, 3'b010, 1'b0, 1'b0);
    run_instr("r_or",   7'h33, 3'b110, 1'b0, 1'b0);
    run_instr("r_and",  7'h33, 3'b111, 1'b1, 1'b0);
    run_instr("r_sll",  7'h33, 3'b001, 1'b0, 1'b0);
    run_instr("i_addi", 7'h13, 3'b000, 1'b1, 1'b0);
    run_instr("i_slti", 7'h13, 3'b010, 1'b0, 1'b1);
  endtask

  task automatic test_branch_jump();
    run_instr("beq_taken",     7'h63, 3'b000, 1'b0, 1'b1);
    run_instr("beq_not_taken", 7'h63, 3'b000, 1'b0, 1'b0);
    run_instr("jal",           7'h6F, 3'b101, 1'b0, 1'b1);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++) begin
      logic [2:0] f3;
      f3 = 3'($urandom_range(0, 7));
      case (i % 3)
        0: run_instr("b2b_r",   7'h33, f3, 1'($urandom_range(0, 1)), 1'b0);
        1: run_instr("b2b_beq", 7'h63, f3, 1'b0, 1'($urandom_range(0, 1)));
        default: run_instr("b2b_lw", 7'h03, f3, 1'b0, 1'b0);
      endcase
    end
  endtask

  task automatic test_illegal();
    run_instr("illegal_op", 7'h7F, 3'b000, 1'b0, 1'b1);
`ifdef ILLEGAL_OP_EN
    total++;
    if (Illegal !== 1'b1 || PCWrite !== 1'b0) begin
      bad++;
      $display("FAIL halt_illegal: got Illegal=%b PCWrite=%b expected Illegal=1 PCWrite=0", Illegal, PCWrite);
    end
    reset = 1'b1;
    #1;
    total++;
    if (Illegal !== 1'b0 || IRWrite !== 1'b1) begin
      bad++;
      $display("FAIL halt_reset: got Illegal=%b IRWrite=%b expected Illegal=0 IRWrite=1", Illegal, IRWrite);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
`endif
    run_instr("after_illegal_jal", 7'h6F, 3'b000, 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_memory();
    test_reset_mid_memread();
    test_alu_ops();
    test_branch_jump();
    test_back_to_back();
    test_illegal();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 The block SHALL have a single clock and an asynchronous, active-high reset. Ports are listed below as name, direction, width, meaning.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 op  input  7  Instr[6:0] from the instruction register.
REQ-005 funct3  input  3  Instr[14:12].
REQ-006 funct7b5  input  1  Instr[30].
REQ-007 Zero  input  1  ALU zero flag.
REQ-008 PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite  output  1 each  datapath enables and selects.
REQ-009 ResultSrc, ALUSrcA, ALUSrcB, ImmSrc  output  2 each  datapath mux selects.
REQ-010 ALUControl  output  3  ALU operation.
REQ-011 Illegal  output  1  sticky illegal-opcode flag; present only when ILLEGAL_OP_EN is defined.

Function
REQ-012 The FSM SHALL use the states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BEQ, JAL, and HALT, with one transition per clk edge.
REQ-013 The FSM SHALL make these transitions:
- FETCH->DECODE.
- DECODE->MEMADR for lw (0000011) or sw (0100011).
- DECODE->EXECUTER for 0110011.
- DECODE->EXECUTEI for 0010011.
- DECODE->BEQ for 1100011.
- DECODE->JAL for 1101111.
- MEMADR->MEMREAD for lw, and MEMADR->MEMWRITE for sw.
- MEMREAD->MEMWB.
- EXECUTER, EXECUTEI and JAL->ALUWB.
- MEMWB, MEMWRITE, ALUWB and BEQ->FETCH.
REQ-014 Every output other than PCWrite in BEQ SHALL be a Moore function of state only. Any output not listed for a state is 0.
REQ-015 FETCH SHALL drive AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, ResultSrc=10, ALUOp=00, PCWrite=1.
REQ-016 DECODE SHALL drive ALUSrcA=01, ALUSrcB=01, ALUOp=00.
REQ-017 MEMADR SHALL drive ALUSrcA=10, ALUSrcB=01, ALUOp=00.
REQ-018 MEMREAD SHALL drive ResultSrc=00, AdrSrc=1.
REQ-019 MEMWB SHALL drive ResultSrc=01, RegWrite=1.
REQ-020 MEMWRITE SHALL drive ResultSrc=00, AdrSrc=1, MemWrite=1.
REQ-021 EXECUTER SHALL drive ALUSrcA=10, ALUSrcB=00, ALUOp=10.
REQ-022 EXECUTEI SHALL drive ALUSrcA=10, ALUSrcB=01, ALUOp=10.
REQ-023 ALUWB SHALL drive ResultSrc=00, RegWrite=1.
REQ-024 BEQ SHALL drive ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, and PCWrite=Zero (combinational).
REQ-025 JAL SHALL drive ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCWrite=1.
REQ-026 ImmSrc SHALL be combinational from op:
- lw and 0010011 -> 00.
- sw -> 01.
- beq -> 10.
- jal -> 11.
- any other op -> 00.
REQ-027 ALUControl SHALL be decoded from ALUOp:
- ALUOp=00 -> 000 (add).
- ALUOp=01 -> 001 (sub).
- ALUOp=10 -> by funct3: 000 -> sub (001) if {op[5],funct7b5}=11, else add (000); 010 -> 101 (slt); 110 -> 011 (or); 111 -> 010 (and); any other funct3 -> 000.
REQ-028 Instruction latency in cycles SHALL be: lw 5, sw 4, R-type 4, I-type 4, beq 3, jal 4.

Reset
REQ-029 An asserted reset SHALL immediately force the state to FETCH, including mid-instruction. Outputs then follow FETCH decode, so reset SHALL not gate outputs.
REQ-030 Reset SHALL clear Illegal to 0.
REQ-031 After reset deasserts, the first rising edge SHALL move FETCH->DECODE.

Configuration
REQ-032 With ILLEGAL_OP_EN defined, an unrecognised op in DECODE SHALL go to HALT. HALT drives every output to 0, self-loops until reset, and sets Illegal=1 from the HALT entry edge.
REQ-033 Without ILLEGAL_OP_EN, an unrecognised op in DECODE SHALL return to FETCH (a 2-cycle nop), the HALT state SHALL not exist, and the Illegal port SHALL not exist.

Structure
REQ-034 Package riscv_pkg SHALL hold the state enum, opcode localparams, ALUOp encodings, and ALUControl encodings.
REQ-035 The ALUOp/funct decode SHALL be placed in the sub-module alu_decoder (combinational). The FSM and the ImmSrc decode SHALL remain in multicycle_controller.

Verification
REQ-036 Reset asserted mid-MEMREAD -> state is FETCH within the same cycle; IRWrite=1, PCWrite=1.
REQ-037 op=0000011, funct3=010 -> states FETCH, DECODE, MEMADR, MEMREAD, MEMWB; RegWrite=1 only in cycle 5; MemWrite is never 1.
REQ-038 op=0110011, funct3=000, funct7b5=1 -> EXECUTER with ALUControl=001; then ALUWB with RegWrite=1.
REQ-039 op=1100011: with Zero=1, PCWrite=1 in the BEQ cycle; with Zero=0, PCWrite=0 in BEQ; both cases return to FETCH next.
REQ-040 op=0100011 -> MEMWRITE asserts MemWrite=1 and AdrSrc=1 for exactly one cycle; ImmSrc=01 throughout.
REQ-041 op=1111111 -> with ILLEGAL_OP_EN: HALT, Illegal=1, and no PCWrite until reset. Without ILLEGAL_OP_EN: FETCH after DECODE.
